// File: rtl/freq_meter_pkg.sv
// Shared constants and types for the equal-precision frequency meter.
// Optional build macro: FREQ_CALC_ROUND_EN (round-to-nearest result in freq_calc).
package freq_meter_pkg;

  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int          CW      = 32;
  localparam logic [31:0] SAT_VAL = 32'hFFFF_FFFF;

  typedef logic [63:0] num_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } calc_state_t;

  // Signal count scaled by the reference clock; 32 + 26 bits always fits in 64.
  function automatic num_t scale_count(input logic [CW-1:0] n);
    return num_t'(n) * num_t'(CLK_HZ);
  endfunction

endpackage

// File: rtl/seq_divider_64_32.sv
// 64/32 restoring divider, one quotient bit per cycle, MSB first (64 iterations).
// The dividend register shifts left and collects quotient bits, so it holds q when done.
module seq_divider_64_32
  import freq_meter_pkg::*;
(
  input  logic        i_clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_start,
  input  logic [63:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [63:0] o_quotient
);

  logic [63:0] r_dvd;
  logic [31:0] r_div;
  logic [32:0] r_rem;
  logic [5:0]  r_cnt;
  logic        r_busy;

  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [32:0] w_rem_nx;

  // Trial subtraction for the current quotient bit
  always_comb begin
    w_rem_sh = {r_rem[31:0], r_dvd[63]};
    w_ge     = (w_rem_sh >= {1'b0, r_div});
    if (w_ge) begin
      w_rem_nx = w_rem_sh - {1'b0, r_div};
    end else begin
      w_rem_nx = w_rem_sh;
    end
  end

  // Iteration state: load on start, shift one bit per cycle while busy
  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      r_dvd  <= 64'd0;
      r_div  <= 32'd0;
      r_rem  <= 33'd0;
      r_cnt  <= 6'd0;
      r_busy <= 1'b0;
    end else if (i_clr) begin
      r_dvd  <= 64'd0;
      r_div  <= 32'd0;
      r_rem  <= 33'd0;
      r_cnt  <= 6'd0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_dvd  <= i_dividend;
      r_div  <= i_divisor;
      r_rem  <= 33'd0;
      r_cnt  <= 6'd63;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_dvd  <= {r_dvd[62:0], w_ge};
      r_rem  <= w_rem_nx;
      r_cnt  <= r_cnt - 6'd1;
      r_busy <= (r_cnt != 6'd0);
    end else begin
      r_dvd  <= r_dvd;
      r_div  <= r_div;
      r_rem  <= r_rem;
      r_cnt  <= r_cnt;
      r_busy <= r_busy;
    end
  end

  // done marks the cycle whose closing edge writes the final quotient bit
  assign o_busy     = r_busy;
  assign o_done     = r_busy & (r_cnt == 6'd0);
  assign o_quotient = r_dvd;

endmodule

// File: rtl/freq_calc.sv
// Frequency calculator: on gate fall captures M/N and computes f = N*CLK_HZ/M.
// Build macro FREQ_CALC_ROUND_EN adds M/2 to the numerator for round-to-nearest.
module freq_calc
  import freq_meter_pkg::*;
(
  input  logic          clk_50M,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_gate_in,
  input  logic [CW-1:0] i_m_in,
  input  logic [CW-1:0] i_n_in,
  output logic [CW-1:0] o_freq_out,
  output logic          o_freq_valid,
  output logic          o_busy,
  output logic          o_err_div0,
  output logic          o_err_ovf
);

  calc_state_t r_state;
  calc_state_t w_state_nx;

  logic          r_gate_d;
  logic          w_fall;
  logic [CW-1:0] r_m;
  logic [CW-1:0] r_n;
  logic          r_div0;
  num_t          w_num;
  logic          w_start;
  logic          w_div_busy;
  logic          w_div_done;
  logic [63:0]   w_quot;

  assign w_fall = r_gate_d & ~i_gate_in;

  // Gate delay for falling-edge detection
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      r_gate_d <= 1'b0;
    end else begin
      r_gate_d <= i_gate_in;
    end
  end

  // Product stage feeds the divider directly during MUL
  always_comb begin
    w_num = scale_count(r_n);
`ifdef FREQ_CALC_ROUND_EN
    w_num = w_num + num_t'(r_m >> 1);
`else
    w_num = w_num + 64'd0;
`endif
  end

  // Next-state logic; clear overrides everything
  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    if (i_clr) begin
      w_state_nx = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            w_state_nx = MUL;
          end else begin
            w_state_nx = IDLE;
          end
        end
        MUL: begin
          if (r_m == {CW{1'b0}}) begin
            w_state_nx = DONE;
          end else begin
            w_state_nx = DIV;
            w_start    = 1'b1;
          end
        end
        DIV: begin
          if (w_div_done) begin
            w_state_nx = DONE;
          end else begin
            w_state_nx = DIV;
          end
        end
        DONE:    w_state_nx = IDLE;
        default: w_state_nx = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Operand capture and divide-by-zero note
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      r_m    <= {CW{1'b0}};
      r_n    <= {CW{1'b0}};
      r_div0 <= 1'b0;
    end else if (i_clr) begin
      r_m    <= {CW{1'b0}};
      r_n    <= {CW{1'b0}};
      r_div0 <= 1'b0;
    end else if ((r_state == IDLE) && w_fall) begin
      r_m    <= i_m_in;
      r_n    <= i_n_in;
      r_div0 <= 1'b0;
    end else if (r_state == MUL) begin
      r_div0 <= (r_m == {CW{1'b0}});
    end else begin
      r_m    <= r_m;
      r_n    <= r_n;
      r_div0 <= r_div0;
    end
  end

  // Registered result, strobe, busy and per-result error flags
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      o_freq_out   <= {CW{1'b0}};
      o_freq_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_err_div0   <= 1'b0;
      o_err_ovf    <= 1'b0;
    end else if (i_clr) begin
      o_freq_out   <= {CW{1'b0}};
      o_freq_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_err_div0   <= 1'b0;
      o_err_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          o_freq_valid <= 1'b0;
          if (w_fall) begin
            o_busy <= 1'b1;
          end else begin
            o_busy <= o_busy;
          end
        end
        DONE: begin
          o_freq_valid <= 1'b1;
          o_busy       <= 1'b0;
          if (r_div0) begin
            o_freq_out <= SAT_VAL;
            o_err_div0 <= 1'b1;
            o_err_ovf  <= 1'b0;
          end else if (w_quot[63:32] != 32'd0) begin
            o_freq_out <= SAT_VAL;
            o_err_div0 <= 1'b0;
            o_err_ovf  <= 1'b1;
          end else begin
            o_freq_out <= w_quot[31:0];
            o_err_div0 <= 1'b0;
            o_err_ovf  <= 1'b0;
          end
        end
        default: begin
          o_freq_valid <= 1'b0;
        end
      endcase
    end
  end

  seq_divider_64_32 u_div (
    .i_clk      (clk_50M),
    .rst        (rst),
    .i_clr      (i_clr),
    .i_start    (w_start),
    .i_dividend (w_num),
    .i_divisor  (r_m),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quot)
  );

endmodule

// File: tb/tb_freq_calc.sv
// Directed self-checking bench for freq_calc (default and FREQ_CALC_ROUND_EN builds).
module tb_freq_calc;

  logic        clk_50M;
  logic        rst;
  logic        i_clr;
  logic        i_gate_in;
  logic [31:0] i_m_in;
  logic [31:0] i_n_in;
  logic [31:0] o_freq_out;
  logic        o_freq_valid;
  logic        o_busy;
  logic        o_err_div0;
  logic        o_err_ovf;

  int checks;
  int errors;

  freq_calc dut (
    .clk_50M      (clk_50M),
    .rst          (rst),
    .i_clr        (i_clr),
    .i_gate_in    (i_gate_in),
    .i_m_in       (i_m_in),
    .i_n_in       (i_n_in),
    .o_freq_out   (o_freq_out),
    .o_freq_valid (o_freq_valid),
    .o_busy       (o_busy),
    .o_err_div0   (o_err_div0),
    .o_err_ovf    (o_err_ovf)
  );

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  // Raise gate for one cycle, then drop it with new M/N; returns #1 after the capture edge.
  task automatic fall_gate(input logic [31:0] m, input logic [31:0] n);
    i_gate_in = 1'b1;
    @(posedge clk_50M); #1;
    i_gate_in = 1'b0;
    i_m_in    = m;
    i_n_in    = n;
    @(posedge clk_50M); #1;
  endtask

  // Edges from the current point until freq_valid is seen; -1 if the budget expires.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk_50M); #1;
      if (o_freq_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; i_clr = 1'b0; i_gate_in = 1'b0; i_m_in = 32'd0; i_n_in = 32'd0;
    #35;
    checks++; if (o_freq_out !== 32'd0)  begin errors++; $display("FAIL reset_freq got %0d exp 0", o_freq_out); end
    checks++; if (o_freq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_freq_valid); end
    checks++; if (o_busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    checks++; if (o_err_div0 !== 1'b0)   begin errors++; $display("FAIL reset_div0 got %b exp 0", o_err_div0); end
    checks++; if (o_err_ovf !== 1'b0)    begin errors++; $display("FAIL reset_ovf got %b exp 0", o_err_ovf); end
    rst = 1'b1;
    repeat (2) @(posedge clk_50M);
    #1;
  endtask

  task automatic test_basic();
    int lat;
    fall_gate(32'd100_000_000, 32'd1000);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", o_busy); end
    wait_valid(lat);
    checks++; if (lat != 66) begin errors++; $display("FAIL basic_latency got %0d exp 66", lat); end
    checks++; if (o_freq_out !== 32'd500) begin errors++; $display("FAIL basic_freq got %0d exp 500", o_freq_out); end
    checks++; if ({o_err_div0, o_err_ovf} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b exp 00", {o_err_div0, o_err_ovf}); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b exp 0", o_busy); end
    @(posedge clk_50M); #1;
    checks++; if (o_freq_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got %b exp 0", o_freq_valid); end
    checks++; if (o_freq_out !== 32'd500) begin errors++; $display("FAIL basic_hold got %0d exp 500", o_freq_out); end
  endtask

  task automatic test_rounding();
    int lat;
    logic [31:0] exp_f;
`ifdef FREQ_CALC_ROUND_EN
    exp_f = 32'd16_666_667;
`else
    exp_f = 32'd16_666_666;
`endif
    repeat (3) @(posedge clk_50M); #1;
    fall_gate(32'd3, 32'd1);
    wait_valid(lat);
    checks++; if (lat != 66) begin errors++; $display("FAIL round_latency got %0d exp 66", lat); end
    checks++; if (o_freq_out !== exp_f) begin errors++; $display("FAIL round_freq got %0d exp %0d", o_freq_out, exp_f); end
  endtask

  task automatic test_div0();
    int lat;
    repeat (3) @(posedge clk_50M); #1;
    fall_gate(32'd0, 32'd7);
    wait_valid(lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL div0_latency got %0d exp 2", lat); end
    checks++; if (o_freq_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_freq got %h exp ffffffff", o_freq_out); end
    checks++; if (o_err_div0 !== 1'b1) begin errors++; $display("FAIL div0_flag got %b exp 1", o_err_div0); end
    checks++; if (o_err_ovf !== 1'b0) begin errors++; $display("FAIL div0_ovf got %b exp 0", o_err_ovf); end
  endtask

  task automatic test_overflow();
    int lat;
    repeat (3) @(posedge clk_50M); #1;
    fall_gate(32'd1, 32'd1000);
    wait_valid(lat);
    checks++; if (lat != 66) begin errors++; $display("FAIL ovf_latency got %0d exp 66", lat); end
    checks++; if (o_freq_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ovf_freq got %h exp ffffffff", o_freq_out); end
    checks++; if (o_err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", o_err_ovf); end
    checks++; if (o_err_div0 !== 1'b0) begin errors++; $display("FAIL ovf_div0 got %b exp 0", o_err_div0); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int extra;
    repeat (3) @(posedge clk_50M); #1;
    fall_gate(32'd100_000_000, 32'd1000);
    repeat (8) @(posedge clk_50M);
    #1;
    fall_gate(32'd5, 32'd7);
    wait_valid(lat);
    checks++; if (lat != 56) begin errors++; $display("FAIL b2b_latency got %0d exp 56", lat); end
    checks++; if (o_freq_out !== 32'd500) begin errors++; $display("FAIL b2b_freq got %0d exp 500", o_freq_out); end
    extra = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk_50M); #1;
      if (o_freq_valid === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL b2b_extra_valid got %0d exp 0", extra); end
  endtask

  task automatic test_clear();
    int lat;
    int seen;
    fall_gate(32'd7, 32'd1);
    repeat (31) @(posedge clk_50M);
    #1;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL clr_pre_busy got %b exp 1", o_busy); end
    i_clr = 1'b1;
    @(posedge clk_50M); #1;
    i_clr = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b exp 0", o_busy); end
    checks++; if (o_freq_out !== 32'd0) begin errors++; $display("FAIL clr_freq got %0d exp 0", o_freq_out); end
    checks++; if (o_freq_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %b exp 0", o_freq_valid); end
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk_50M); #1;
      if (o_freq_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL clr_discard got %0d exp 0", seen); end
    fall_gate(32'd4, 32'd2);
    wait_valid(lat);
    checks++; if (lat != 66) begin errors++; $display("FAIL clr_after_latency got %0d exp 66", lat); end
    checks++; if (o_freq_out !== 32'd25_000_000) begin errors++; $display("FAIL clr_after_freq got %0d exp 25000000", o_freq_out); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_rounding();
    test_div0();
    test_overflow();
    test_back_to_back();
    test_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
